// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two ports of alu_arbiter.
// The master side issues jobs; the slave side (the arbiter) accepts them and returns results.
interface alu_arbiter_if #(
    parameter int N = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_op;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [N-1:0] rsp0_r;
    logic [3:0]   rsp0_flags;
    logic         rsp0_err;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp1_r;
    logic [3:0]   rsp1_flags;
    logic         rsp1_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_r, rsp0_flags, rsp0_err,
        input  rsp1_valid, rsp1_r, rsp1_flags, rsp1_err,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_r, rsp0_flags, rsp0_err,
        output rsp1_valid, rsp1_r, rsp1_flags, rsp1_err,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-port response counters stat_cnt0/stat_cnt1.
module alu_arbiter #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_cntr,
    input  logic [N-1:0]  alu_r,
    input  logic [3:0]    alu_flags
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]   stat_cnt0,
    output logic [15:0]   stat_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         gnt_id;     // port owning the outstanding transaction
    logic         rr_ptr;     // port preferred when both request
    logic         grant_vld;
    logic         grant_sel;
    logic         op_legal;
    logic         rsp_fire;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [2:0]   sel_op;
    logic [N-1:0] r_q;
    logic [3:0]   flags_q;
    logic         err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state is written with non-blocking assignments only.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_nxt = state;
        grant_vld = 1'b0;
        grant_sel = rr_ptr;
        rsp_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = rr_ptr;
                end else if (bus.req0_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b0;
                end else if (bus.req1_valid) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_vld) begin
                    state_nxt = op_legal ? ISSUE : RESP;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                rsp_fire = gnt_id ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_a    = grant_sel ? bus.req1_a  : bus.req0_a;
    assign sel_b    = grant_sel ? bus.req1_b  : bus.req0_b;
    assign sel_op   = grant_sel ? bus.req1_op : bus.req0_op;
    assign op_legal = (sel_op <= 3'd5);

    // Datapath: illegal ops skip the ALU and report an error response directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_id   <= 1'b0;
            rr_ptr   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cntr <= '0;
            r_q      <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && grant_vld) begin
                gnt_id <= grant_sel;
                if (op_legal) begin
                    alu_a    <= sel_a;
                    alu_b    <= sel_b;
                    alu_cntr <= sel_op;
                end else begin
                    r_q     <= '0;
                    flags_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                r_q     <= alu_r;
                flags_q <= alu_flags;
                err_q   <= 1'b0;
            end
            if (rsp_fire) begin
                rr_ptr <= ~gnt_id;
            end
        end
    end

    assign bus.req0_ready = grant_vld && !grant_sel;
    assign bus.req1_ready = grant_vld && grant_sel;

    assign bus.rsp0_valid = (state == RESP) && !gnt_id;
    assign bus.rsp1_valid = (state == RESP) && gnt_id;
    assign bus.rsp0_r     = r_q;
    assign bus.rsp1_r     = r_q;
    assign bus.rsp0_flags = flags_q;
    assign bus.rsp1_flags = flags_q;
    assign bus.rsp0_err   = err_q;
    assign bus.rsp1_err   = err_q;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (rsp_fire) begin
            if (!gnt_id && stat_cnt0 != 16'hFFFF) stat_cnt0 <= stat_cnt0 + 16'd1;
            if (gnt_id && stat_cnt1 != 16'hFFFF) stat_cnt1 <= stat_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_cntr;
    logic [N-1:0] alu_r;
    logic [3:0]   alu_flags;
    logic [N:0]   alu_t;
    logic         alu_c;
    logic         alu_v;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]  stat_cnt0;
    logic [15:0]  stat_cnt1;
`endif

    always #5 clk = ~clk;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cntr  (alu_cntr),
        .alu_r     (alu_r),
        .alu_flags (alu_flags)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_cnt0 (stat_cnt0),
        .stat_cnt1 (stat_cnt1)
`endif
    );

    // Shared ALU: C is carry on add and not-borrow on sub; V is signed overflow.
    always_comb begin
        alu_t = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_cntr)
            3'd0: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = alu_t[N];
                alu_v = (alu_a[N-1] == alu_b[N-1]) && (alu_t[N-1] != alu_a[N-1]);
            end
            3'd1: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c = ~alu_t[N];
                alu_v = (alu_a[N-1] != alu_b[N-1]) && (alu_t[N-1] != alu_a[N-1]);
            end
            3'd2:    alu_t = {1'b0, alu_a & alu_b};
            3'd3:    alu_t = {1'b0, alu_a | alu_b};
            3'd4:    alu_t = {1'b0, ~alu_b};
            3'd5:    alu_t = {1'b0, alu_b};
            default: alu_t = '0;
        endcase
        alu_r     = alu_t[N-1:0];
        alu_flags = {alu_v, alu_r[N-1], alu_c, (alu_r == '0)};
    end

    typedef struct {
        bit         port;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] r;
        logic [3:0] flags;
        bit         err;
    } vec_t;

    vec_t vecs[11];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input bit p, input bit v, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op);
        if (!p) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    function automatic logic rdy(input bit p);
        return p ? bus.req1_ready : bus.req0_ready;
    endfunction
    function automatic logic rvld(input bit p);
        return p ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction
    function automatic logic [7:0] rres(input bit p);
        return p ? bus.rsp1_r : bus.rsp0_r;
    endfunction
    function automatic logic [3:0] rflg(input bit p);
        return p ? bus.rsp1_flags : bus.rsp0_flags;
    endfunction
    function automatic logic rerr(input bit p);
        return p ? bus.rsp1_err : bus.rsp0_err;
    endfunction

    // Reference ALU computed with plain integer arithmetic.
    task automatic ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           output logic [7:0] r, output logic [3:0] f, output bit e);
        int ua, ub, sa, sb, u, s;
        bit c, v;
        ua = int'(a); ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 0; v = 0; e = 0; u = 0; s = 0;
        case (op)
            3'd0: begin u = ua + ub; s = sa + sb; c = (u > 255); v = (s > 127 || s < -128); end
            3'd1: begin u = ua - ub; s = sa - sb; c = (ua >= ub); v = (s > 127 || s < -128); end
            3'd2: u = int'(a & b);
            3'd3: u = int'(a | b);
            3'd4: u = 255 - ub;
            3'd5: u = ub;
            default: e = 1;
        endcase
        if (e) begin
            r = 8'h00; f = 4'h0;
        end else begin
            r = 8'(u & 255);
            f = {v, r[7], c, (r == 8'h00)};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_req(0, 0, 8'h00, 8'h00, 3'd0);
        drive_req(1, 0, 8'h00, 8'h00, 3'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) at negedges for req ready of port p; returns with valid still high.
    task automatic wait_ready(input bit p, input string tag, output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (rdy(p)) seen = 1;
            else @(negedge clk);
        end
        check({tag, " grant"}, 32'(seen), 32'(1));
    endtask

    // Called at the negedge right after the handshake edge; returns cycles until rsp valid.
    task automatic wait_rsp(input bit p, input string tag, output int lat);
        bit seen;
        seen = 0;
        lat = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (rvld(p)) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, " rsp seen"}, 32'(seen), 32'(1));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        bit seen;
        int lat;
        @(negedge clk);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive_req(v.port, 1, v.a, v.b, v.op);
        wait_ready(v.port, tag, seen);
        @(negedge clk);
        drive_req(v.port, 0, v.a, v.b, v.op);
        if (!seen) return;
        wait_rsp(v.port, tag, lat);
        check({tag, " latency"}, 32'(lat), v.err ? 32'd1 : 32'd2);
        check({tag, " r"}, 32'(rres(v.port)), 32'(v.r));
        check({tag, " flags"}, 32'(rflg(v.port)), 32'(v.flags));
        check({tag, " err"}, 32'(rerr(v.port)), 32'(v.err));
        check({tag, " other rsp idle"}, 32'(rvld(!v.port)), 32'(0));
        @(negedge clk);
        #1;
        check({tag, " rsp consumed"}, 32'(rvld(v.port)), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] last_a, last_b;
        logic [2:0] last_op;
        bit         seen;
        int         lat;
        int         grants[4];
        int         gcyc[4];
        int         ng, nr0, nr1;
        logic [7:0] hold_r;
        logic [3:0] hold_f;

        vecs[0]  = '{1'b0, 8'h05, 8'h03, 3'd0, 8'h08, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 8'h03, 8'h03, 3'd1, 8'h00, 4'b0011, 1'b0};
        vecs[2]  = '{1'b0, 8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 8'h0F, 8'hF0, 3'd3, 8'hFF, 4'b0100, 1'b0};
        vecs[4]  = '{1'b0, 8'h12, 8'hFF, 3'd4, 8'h00, 4'b0001, 1'b0};
        vecs[5]  = '{1'b1, 8'h44, 8'h80, 3'd5, 8'h80, 4'b0100, 1'b0};
        vecs[6]  = '{1'b0, 8'h01, 8'h02, 3'd1, 8'hFF, 4'b0100, 1'b0};
        vecs[7]  = '{1'b0, 8'h9A, 8'h77, 3'd6, 8'h00, 4'b0000, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0011, 1'b0};
        vecs[9]  = '{1'b1, 8'h5A, 8'hA5, 3'd7, 8'h00, 4'b0000, 1'b1};
        vecs[10] = '{1'b1, 8'h80, 8'h01, 3'd1, 8'h7F, 4'b1010, 1'b0};

        // Reset state
        rst = 1'b1;
        drive_req(0, 0, 8'h00, 8'h00, 3'd0);
        drive_req(1, 0, 8'h00, 8'h00, 3'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset alu_a", 32'(alu_a), 32'(0));
        check("reset alu_b", 32'(alu_b), 32'(0));
        check("reset alu_cntr", 32'(alu_cntr), 32'(0));
        check("reset rsp valids", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'(0));
        check("reset req readys", 32'({bus.req0_ready, bus.req1_ready}), 32'(0));
        check("reset rsp0 data", 32'({bus.rsp0_r, bus.rsp0_flags, bus.rsp0_err}), 32'(0));
        rst = 1'b0;

        // Directed vector table, single requester each
        last_a = 8'h00; last_b = 8'h00; last_op = 3'd0;
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].err) begin
                last_a = vecs[i].a; last_b = vecs[i].b; last_op = vecs[i].op;
            end
            check($sformatf("vec%0d alu held", i), 32'({alu_a, alu_b, alu_cntr}),
                  32'({last_a, last_b, last_op}));
        end

        // Both ports requesting every cycle: alternation and 3-cycle spacing
        do_reset();
        @(negedge clk);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive_req(0, 1, 8'h7F, 8'h01, 3'd0);
        drive_req(1, 1, 8'hF0, 8'h3C, 3'd2);
        ng = 0; nr0 = 0; nr1 = 0;
        for (int i = 0; i < 40 && (ng < 4 || nr0 + nr1 < 4); i++) begin
            #1;
            if (ng < 4 && (bus.req0_ready || bus.req1_ready)) begin
                grants[ng] = bus.req1_ready ? 1 : 0;
                gcyc[ng] = i;
                ng++;
            end
            if (bus.rsp0_valid) begin
                nr0++;
                check("alt rsp0 r", 32'(bus.rsp0_r), 32'(8'h80));
                check("alt rsp0 flags", 32'(bus.rsp0_flags), 32'(4'b1100));
            end
            if (bus.rsp1_valid) begin
                nr1++;
                check("alt rsp1 r", 32'(bus.rsp1_r), 32'(8'h30));
                check("alt rsp1 flags", 32'(bus.rsp1_flags), 32'(4'b0000));
            end
            @(negedge clk);
            if (ng >= 4) begin
                drive_req(0, 0, 8'h00, 8'h00, 3'd0);
                drive_req(1, 0, 8'h00, 8'h00, 3'd0);
            end
        end
        check("alt grant count", 32'(ng), 32'(4));
        check("alt rsp counts", 32'({nr0[7:0], nr1[7:0]}), 32'({8'd2, 8'd2}));
        for (int k = 0; k < ng; k++) begin
            check($sformatf("alt grant%0d port", k), 32'(grants[k]), 32'(k % 2));
            if (k > 0) check($sformatf("alt grant%0d spacing", k), 32'(gcyc[k] - gcyc[k-1]), 32'(3));
        end

        // Response backpressure on port 0 while port 1 waits
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        drive_req(0, 1, 8'h10, 8'h20, 3'd1);
        wait_ready(0, "bp req0", seen);
        @(negedge clk);
        drive_req(0, 0, 8'h00, 8'h00, 3'd0);
        drive_req(1, 1, 8'h0F, 8'h30, 3'd3);
        wait_rsp(0, "bp rsp0", lat);
        hold_r = 8'hF0;
        hold_f = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("bp rsp0 valid", 32'(bus.rsp0_valid), 32'(1));
            check("bp rsp0 r", 32'(bus.rsp0_r), 32'(hold_r));
            check("bp rsp0 flags", 32'(bus.rsp0_flags), 32'(hold_f));
            check("bp req1 ready", 32'(bus.req1_ready), 32'(0));
        end
        @(negedge clk);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp rsp0 dropped", 32'(bus.rsp0_valid), 32'(0));
        check("bp req1 granted", 32'(bus.req1_ready), 32'(1));
        @(negedge clk);
        drive_req(1, 0, 8'h00, 8'h00, 3'd0);
        wait_rsp(1, "bp rsp1", lat);
        check("bp rsp1 r", 32'(bus.rsp1_r), 32'(8'h3F));
        check("bp rsp1 latency", 32'(lat), 32'(2));

        // Reset in ISSUE: pointer must return to port 0 after the last port-0 service
        run_txn(vecs[0], "pre-rst");
        @(negedge clk);
        drive_req(0, 1, 8'hAA, 8'h55, 3'd0);
        wait_ready(0, "rst req0", seen);
        @(negedge clk);
        drive_req(0, 0, 8'h00, 8'h00, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst alu", 32'({alu_a, alu_b, alu_cntr}), 32'(0));
        check("rst rsp valids", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'(0));
        check("rst rsp0 data", 32'({bus.rsp0_r, bus.rsp0_flags, bus.rsp0_err}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post-rst no rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'(0));
        end
        @(negedge clk);
        drive_req(0, 1, 8'h01, 8'h01, 3'd0);
        drive_req(1, 1, 8'h02, 8'h02, 3'd0);
        #1;
        check("post-rst grant", 32'({bus.req0_ready, bus.req1_ready}), 32'(2'b10));
        @(negedge clk);
        drive_req(0, 0, 8'h00, 8'h00, 3'd0);
        drive_req(1, 0, 8'h00, 8'h00, 3'd0);
        wait_rsp(0, "post-rst rsp0", lat);
        check("post-rst rsp0 r", 32'(bus.rsp0_r), 32'(8'h02));

        // Randomized traffic against the transaction-level model
        do_reset();
        begin
            bit         job_valid[2];
            logic [7:0] job_a[2];
            logic [7:0] job_b[2];
            logic [2:0] job_op[2];
            bit         inflight, inf_port, pref, done;
            int         inf_age, inf_lat, eg;
            logic [7:0] inf_r;
            logic [3:0] inf_f;
            bit         inf_e;
            job_valid[0] = 0; job_valid[1] = 0;
            inflight = 0; inf_port = 0; pref = 0;
            inf_age = 0; inf_lat = 0;
            inf_r = '0; inf_f = '0; inf_e = 0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin
                    if (!job_valid[p] && $urandom_range(0, 2) == 0) begin
                        job_valid[p] = 1;
                        job_a[p]  = 8'($urandom);
                        job_b[p]  = 8'($urandom);
                        job_op[p] = 3'($urandom_range(0, 7));
                    end
                    drive_req(p[0], job_valid[p], job_a[p], job_b[p], job_op[p]);
                end
                bus.rsp0_ready = ($urandom_range(0, 2) != 0);
                bus.rsp1_ready = ($urandom_range(0, 2) != 0);
                #1;
                eg = -1;
                if (!inflight) begin
                    if (job_valid[0] && job_valid[1]) eg = pref ? 1 : 0;
                    else if (job_valid[0]) eg = 0;
                    else if (job_valid[1]) eg = 1;
                end
                check("rand req0_ready", 32'(bus.req0_ready), 32'(eg == 0));
                check("rand req1_ready", 32'(bus.req1_ready), 32'(eg == 1));
                check("rand rsp0_valid", 32'(bus.rsp0_valid),
                      32'(inflight && !inf_port && inf_age >= inf_lat));
                check("rand rsp1_valid", 32'(bus.rsp1_valid),
                      32'(inflight && inf_port && inf_age >= inf_lat));
                done = 0;
                if (inflight && inf_age >= inf_lat &&
                    (inf_port ? bus.rsp1_ready : bus.rsp0_ready)) begin
                    check("rand rsp r", 32'(rres(inf_port)), 32'(inf_r));
                    check("rand rsp flags", 32'(rflg(inf_port)), 32'(inf_f));
                    check("rand rsp err", 32'(rerr(inf_port)), 32'(inf_e));
                    done = 1;
                end
                if (done) begin
                    inflight = 0;
                    pref = !inf_port;
                end else if (inflight) begin
                    inf_age++;
                end
                if (eg >= 0) begin
                    inflight = 1;
                    inf_port = eg[0];
                    inf_age  = 1;
                    ref_alu(job_a[eg], job_b[eg], job_op[eg], inf_r, inf_f, inf_e);
                    inf_lat = inf_e ? 1 : 2;
                    job_valid[eg] = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-port round-robin arbiter and sequencer that shares one combinational ALU (N-bit operands, 3-bit op select, 4-bit flags) between two requesters. Each request carries A, B and an op code over a valid/ready handshake. The block registers the operands, drives the ALU for one cycle, captures result and flags, and returns them on a per-port valid/ready response channel. It sits between the control logic that issues arithmetic jobs and the shared ALU instance.

Parameters:
N, 8, operand/result width in bits (must match the ALU instance)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_a  input  N  port 0 operand A
req0_b  input  N  port 0 operand B
req0_op  input  3  port 0 op: 0 add, 1 sub, 2 and, 3 or, 4 not B, 5 move B, 6/7 illegal
req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths as port 0, for port 1
rsp0_valid  output  1  port 0 response valid
rsp0_ready  input  1  port 0 response consumed
rsp0_r  output  N  port 0 result
rsp0_flags  output  4  port 0 flags {V,N,C,Z} = bits [3:0] as {3:V, 2:N, 1:C, 0:Z}
rsp0_err  output  1  port 0 illegal op reported
rsp1_valid, rsp1_ready, rsp1_r, rsp1_flags, rsp1_err  same directions/widths as port 0, for port 1
alu_a  output  N  ALU operand A (registered)
alu_b  output  N  ALU operand B (registered)
alu_cntr  output  3  ALU op select (registered)
alu_r  input  N  ALU result (combinational from alu_a/b/cntr)
alu_flags  input  4  ALU flags, same bit layout as rspX_flags

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr pointer favours port 0; captured transaction dropped with no response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: reqX_ready is combinational and equals grant to X. Grant to a single valid requester; if both are valid, grant the port not served last. At most one ready high per cycle. On handshake, latch a, b, op and grant id.
  - Legal op (0-5): load alu_a, alu_b, alu_cntr from the request; go to ISSUE.
  - Illegal op (6/7): ALU not driven; capture r=0, flags=0, err=1; go to RESP.
- ISSUE: exactly one cycle. alu_* stable; at the clock edge sample alu_r and alu_flags into the response registers, err=0; go to RESP.
- RESP: rspX_valid=1 only for the granted port; r/flags/err held stable. On rspX_ready=1, drop valid, flip the rr pointer to the other port, and go to IDLE.
- Latency: handshake at edge T; rsp valid from T+2 (legal) or T+1 (illegal).
- Minimum period: 3 cycles per legal op with rsp_ready tied high.
- One transaction outstanding. reqX_ready=0 in ISSUE and RESP.
- alu_* hold their last value outside ISSUE; reset value 0.
- Requests may deassert valid before ready without penalty. No fairness claim across a withdrawn request.
- rsp_ready asserted on the non-granted port: ignored.
- Response backpressure: stay in RESP indefinitely, and requests of both ports stall.
- Result/flags are passed through verbatim. No width extension or modification.

Optional Feature:
ALU_ARB_STATS_EN: when defined, adds outputs stat_cnt0 and stat_cnt1 (16 bits each). Each counts completed responses per port (rsp handshake), saturates at 16'hFFFF, and resets to 0. When undefined, these ports and their counters are absent and all other behaviour is identical.

Test Plan:
- Port 0: add, a=8'h05, b=8'h03 -> rsp0_valid at T+2, rsp0_r=8'h08, flags=4'b0000, err=0; req1 idle, rsp1_valid stays 0.
- Port 1: sub, a=b=8'h03 -> rsp1_r=8'h00, flags Z=1 and C=1 (4'b0011), matching the bench ALU model.
- Both valid every cycle, rsp_ready=1: port 0 add 8'h7F+8'h01, port 1 and 8'hF0&8'h3C. Expected: grants alternate 0,1,0,1; port 0 gets r=8'h80, flags=4'b1100; port 1 gets r=8'h30; 3-cycle spacing.
- Port 0: op=3'b110 -> rsp0_valid at T+1, r=0, flags=0, err=1; alu_* unchanged.
- rsp0_ready=0 for 10 cycles after valid -> r/flags stable; req1_valid=1 with req1_ready held 0 throughout; port 1 granted on the cycle after the rsp0 handshake.
- rst pulse during ISSUE -> all outputs 0 immediately (async); no response after release; next request granted to port 0.
